// File: rtl/g_reg_scoreboard_if.sv
// Decode/write-back bus of the register scoreboard. The master side belongs to the pipeline.
// The slave side belongs to the register file.
interface g_reg_scoreboard_if #(
    parameter int XLEN = 32,
    parameter int NREG = 16,
    parameter int W_RD = 4
);
    logic [W_RD-1:0] r0_i;
    logic [W_RD-1:0] r1_i;
    logic            r0_v_i;
    logic            r1_v_i;
    logic [XLEN-1:0] r_opr0_o;
    logic [XLEN-1:0] r_opr1_o;
    logic            reserved_o;
    logic            w_reserve_i;
    logic [W_RD-1:0] w_rd_i;
    logic            reserve_full_o;
    logic            wb0_i;
    logic [W_RD-1:0] wb0_r_i;
    logic [XLEN-1:0] wb0_data_i;
    logic            wb1_i;
    logic [W_RD-1:0] wb1_r_i;
    logic [XLEN-1:0] wb1_data_i;
    logic            flush_i;
    logic [NREG-1:0] busy_o;

    modport master (
        output r0_i, r1_i, r0_v_i, r1_v_i, w_reserve_i, w_rd_i,
               wb0_i, wb0_r_i, wb0_data_i, wb1_i, wb1_r_i, wb1_data_i, flush_i,
        input  r_opr0_o, r_opr1_o, reserved_o, reserve_full_o, busy_o
    );

    modport slave (
        input  r0_i, r1_i, r0_v_i, r1_v_i, w_reserve_i, w_rd_i,
               wb0_i, wb0_r_i, wb0_data_i, wb1_i, wb1_r_i, wb1_data_i, flush_i,
        output r_opr0_o, r_opr1_o, reserved_o, reserve_full_o, busy_o
    );
endinterface

// File: rtl/g_reg_scoreboard.sv
// Register file with a saturating pending-write counter per register.
// It also provides same-cycle write-back bypass, flush, and an optional hard-wired zero register.
module g_reg_scoreboard #(
    parameter int XLEN     = 32,
    parameter int NREG     = 16,
    parameter int W_RD     = 4,
    parameter int CNT_W    = 2,
    parameter int ZERO_REG = 0
) (
    input logic               clk,
    input logic               reset,
    g_reg_scoreboard_if.slave bus
);
    localparam int CW = CNT_W + 2;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [XLEN-1:0]  regs_q [NREG];
    logic [XLEN-1:0]  regs_d [NREG];
    logic [CNT_W-1:0] cnt_q  [NREG];
    logic [CNT_W-1:0] cnt_d  [NREG];
    logic             reserveFull;

    function automatic logic isZero(input logic [W_RD-1:0] r);
        return (ZERO_REG != 0) && (r == '0);
    endfunction

    function automatic logic [1:0] wbHits(input logic [W_RD-1:0] r);
        return {1'b0, bus.wb0_i && (bus.wb0_r_i == r)} + {1'b0, bus.wb1_i && (bus.wb1_r_i == r)};
    endfunction

    // Bypass: write-back port 1 has priority over port 0, and port 0 has priority over the array.
    function automatic logic [XLEN-1:0] readData(input logic [W_RD-1:0] r);
        if (isZero(r))                        return '0;
        else if (bus.wb1_i && bus.wb1_r_i == r) return bus.wb1_data_i;
        else if (bus.wb0_i && bus.wb0_r_i == r) return bus.wb0_data_i;
        else                                    return regs_q[r];
    endfunction

    // A source stalls only while its pending count exceeds the write-backs landing this cycle.
    function automatic logic pending(input logic [W_RD-1:0] r, input logic v);
        return v && (CW'(cnt_q[r]) > CW'(wbHits(r)));
    endfunction

    always_comb begin
        bus.r_opr0_o   = readData(bus.r0_i);
        bus.r_opr1_o   = readData(bus.r1_i);
        bus.reserved_o = pending(bus.r0_i, bus.r0_v_i) | pending(bus.r1_i, bus.r1_v_i);
        reserveFull    = bus.w_reserve_i && (cnt_q[bus.w_rd_i] == CNT_MAX);
        bus.reserve_full_o = reserveFull;
        bus.busy_o     = '0;
        for (int n = 0; n < NREG; n++) begin
            bus.busy_o[n] = |cnt_q[n];
        end
    end

    always_comb begin
        regs_d = regs_q;
        if (bus.wb0_i && !isZero(bus.wb0_r_i)) regs_d[bus.wb0_r_i] = bus.wb0_data_i;
        if (bus.wb1_i && !isZero(bus.wb1_r_i)) regs_d[bus.wb1_r_i] = bus.wb1_data_i;
    end

    // The net count is applied, and surplus write-backs clamp the count at zero.
    always_comb begin
        logic          inc;
        logic [CW-1:0] sum;
        logic [CW-1:0] dec;
        for (int n = 0; n < NREG; n++) begin
            inc = bus.w_reserve_i && (bus.w_rd_i == W_RD'(n)) && !reserveFull
                  && !bus.flush_i && !isZero(W_RD'(n));
            sum = CW'(cnt_q[n]) + CW'(inc);
            dec = CW'(wbHits(W_RD'(n)));
            if (bus.flush_i || dec >= sum) cnt_d[n] = '0;
            else                           cnt_d[n] = CNT_W'(sum - dec);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int n = 0; n < NREG; n++) begin
                regs_q[n] <= '0;
                cnt_q[n]  <= '0;
            end
        end else begin
            regs_q <= regs_d;
            cnt_q  <= cnt_d;
        end
    end
endmodule
